// File: rtl/ws2812_receiver.sv
// WS2812B NZR line decoder: measures high times, assembles 24-bit GRB pixels, flags frame resets and protocol errors.
// Latency 4 clk from the 24th bit's falling edge to pixelValid; no backpressure, all results are single-cycle pulses.
module ws2812_receiver #(
    parameter int THRESH    = 60,
    parameter int MIN_HIGH  = 15,
    parameter int MAX_HIGH  = 110,
    parameter int RESET_LOW = 28000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dataIn,
    output logic [23:0] pixel,
    output logic        pixelValid,
    output logic [12:0] pixelIndex,
    output logic        frameDone,
    output logic        err,
    output logic        busy
);

    localparam logic [6:0]  TH_C   = 7'(THRESH);
    localparam logic [6:0]  MINH_C = 7'(MIN_HIGH);
    localparam logic [6:0]  MAXH_C = 7'(MAX_HIGH);
    localparam logic [14:0] RL_C   = 15'(RESET_LOW);

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    state_t      state_q, state_d;
    logic        sync1_q, din_s_q, din_d_q;
    logic [14:0] lcnt_q, lcnt_d;
    logic [6:0]  hcnt_q, hcnt_d;
    logic [4:0]  bitcnt_q, bitcnt_d;
    logic [23:0] shreg_q, shreg_d;
    logic [12:0] ptr_q, ptr_d;
    logic [23:0] pixel_q, pixel_d;
    logic [12:0] pidx_q, pidx_d;
    logic        pv_q, pv_d;
    logic        fd_q, fd_d;
    logic        err_q, err_d;
    logic        rise, fall;

    assign rise = din_s_q & ~din_d_q;
    assign fall = ~din_s_q & din_d_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= SYNC;
            sync1_q  <= 1'b0;
            din_s_q  <= 1'b0;
            din_d_q  <= 1'b0;
            lcnt_q   <= '0;
            hcnt_q   <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            ptr_q    <= '0;
            pixel_q  <= '0;
            pidx_q   <= '0;
            pv_q     <= 1'b0;
            fd_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= dataIn;
            din_s_q  <= sync1_q;
            din_d_q  <= din_s_q;
            lcnt_q   <= lcnt_d;
            hcnt_q   <= hcnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            ptr_q    <= ptr_d;
            pixel_q  <= pixel_d;
            pidx_q   <= pidx_d;
            pv_q     <= pv_d;
            fd_q     <= fd_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lcnt_d   = lcnt_q;
        hcnt_d   = hcnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        ptr_d    = ptr_q;
        pixel_d  = pixel_q;
        pidx_d   = pidx_q;
        pv_d     = 1'b0;
        fd_d     = 1'b0;
        err_d    = 1'b0;

        // Pixel completion runs alongside the state logic: a 1-cycle low may already carry a new rising edge.
        if (bitcnt_q == 5'd24) begin
            pixel_d  = shreg_q;
            pidx_d   = ptr_q;
            pv_d     = 1'b1;
            ptr_d    = ptr_q + 13'd1;
            bitcnt_d = '0;
        end

        case (state_q)
            SYNC: begin
                if (din_s_q) begin
                    lcnt_d = '0;
                end else if (lcnt_q == RL_C) begin
                    state_d = IDLE;
                end else begin
                    lcnt_d = lcnt_q + 15'd1;
                end
            end
            IDLE: begin
                if (rise) begin
                    state_d  = HIGH;
                    hcnt_d   = 7'd1;
                    bitcnt_d = '0;
                    ptr_d    = '0;
                end
            end
            HIGH: begin
                if (hcnt_q > MAXH_C) begin
                    err_d    = 1'b1;
                    state_d  = SYNC;
                    lcnt_d   = '0;
                    bitcnt_d = '0;
                end else if (fall) begin
                    if (hcnt_q < MINH_C) begin
                        err_d    = 1'b1;
                        state_d  = SYNC;
                        lcnt_d   = '0;
                        bitcnt_d = '0;
                    end else begin
                        shreg_d  = {shreg_q[22:0], (hcnt_q >= TH_C)};
                        bitcnt_d = bitcnt_q + 5'd1;
                        lcnt_d   = 15'd1;
                        state_d  = LOW;
                    end
                end else if (hcnt_q != 7'h7f) begin
                    hcnt_d = hcnt_q + 7'd1;
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                    hcnt_d  = 7'd1;
                end else if (lcnt_q == RL_C) begin
                    fd_d    = 1'b1;
                    ptr_d   = '0;
                    state_d = IDLE;
                    if (bitcnt_q != 5'd0) begin
                        err_d    = 1'b1;
                        bitcnt_d = '0;
                    end
                end else begin
                    lcnt_d = lcnt_q + 15'd1;
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_comb begin
        busy       = (state_q == HIGH) || (state_q == LOW);
        pixel      = pixel_q;
        pixelIndex = pidx_q;
        pixelValid = pv_q;
        frameDone  = fd_q;
        err        = err_q;
    end

endmodule
